// File: rtl/rgb_pwm_driver.sv
// rtl/rgb_pwm_driver.sv - debounced RGB comparator indicator with PWM dimming and change flash
module rgb_pwm_driver #(
  parameter int STABLE_CYC = 4,
  parameter int FLASH_CYC  = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       red_in,
  input  logic       green_in,
  input  logic       blue_in,
  input  logic [7:0] brightness,
  input  logic       en,
  output logic       led_r,
  output logic       led_g,
  output logic       led_b,
  output logic       flashing,
  output logic       illegal
);

  typedef enum logic {
    IDLE  = 1'b0,
    FLASH = 1'b1
  } state_t;

  localparam logic [7:0]  STABLE_LIM = 8'(STABLE_CYC);
  localparam logic [15:0] FLASH_LOAD = 16'(FLASH_CYC - 1);

  // Triple ordering is {r, g, b} throughout.
  logic [2:0]  sync1_q, sync2_q;
  logic [2:0]  cand_q, cand_d;
  logic [2:0]  acc_q, acc_d;
  logic [7:0]  stab_q, stab_d;
  logic [7:0]  pwm_q;
  logic [7:0]  bright_q;
  logic [15:0] flash_cnt_q;
  state_t      state_q;
  logic        acc_change;
  logic        acc_legal;
  logic        pwm_on;

  // Acceptance: a candidate must survive STABLE_CYC synchronized cycles before it replaces the accepted triple.
  always_comb begin
    cand_d = cand_q;
    stab_d = stab_q;
    acc_d  = acc_q;
    if (sync2_q != cand_q) begin
      cand_d = sync2_q;
      stab_d = 8'd1;
    end else if (stab_q != 8'hFF) begin
      stab_d = stab_q + 8'd1;
    end
    if ((stab_d >= STABLE_LIM) && (cand_d != acc_q)) begin
      acc_d = cand_d;
    end
    acc_change = (acc_d != acc_q);
    acc_legal  = (acc_d == 3'b101) || (acc_d == 3'b011) || (acc_d == 3'b110);
    pwm_on     = (pwm_q < bright_q);
  end

  // Synchronizers, debounce state, PWM counter and the sticky illegal flag; these run regardless of en.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q  <= 3'b000;
      sync2_q  <= 3'b000;
      cand_q   <= 3'b000;
      stab_q   <= 8'd0;
      acc_q    <= 3'b000;
      pwm_q    <= 8'd0;
      bright_q <= 8'd0;
      illegal  <= 1'b0;
    end else begin
      sync1_q <= {red_in, green_in, blue_in};
      sync2_q <= sync1_q;
      cand_q  <= cand_d;
      stab_q  <= stab_d;
      acc_q   <= acc_d;
      pwm_q   <= pwm_q + 8'd1;
      // Duty is only picked up at the period boundary so a period never mixes two duties.
      if (pwm_q == 8'hFF) begin
        bright_q <= brightness;
      end
      if (acc_change && !acc_legal) begin
        illegal <= 1'b1;
      end
    end
  end

  // Flash FSM with registered LED and flashing outputs; en low parks it in IDLE and blanks the outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      flash_cnt_q <= 16'd0;
      led_r       <= 1'b0;
      led_g       <= 1'b0;
      led_b       <= 1'b0;
      flashing    <= 1'b0;
    end else begin
      if (!en) begin
        state_q     <= IDLE;
        flash_cnt_q <= 16'd0;
      end else begin
        case (state_q)
          IDLE: begin
            if (acc_change) begin
              state_q     <= FLASH;
              flash_cnt_q <= FLASH_LOAD;
            end
          end
          FLASH: begin
            if (acc_change) begin
              flash_cnt_q <= FLASH_LOAD;
            end else if (flash_cnt_q == 16'd0) begin
              state_q <= IDLE;
            end else begin
              flash_cnt_q <= flash_cnt_q - 16'd1;
            end
          end
          default: begin
            state_q <= IDLE;
          end
        endcase
      end

      if (!en) begin
        led_r    <= 1'b0;
        led_g    <= 1'b0;
        led_b    <= 1'b0;
        flashing <= 1'b0;
      end else if (state_q == FLASH) begin
        led_r    <= acc_q[2];
        led_g    <= acc_q[1];
        led_b    <= acc_q[0];
        flashing <= 1'b1;
      end else begin
        led_r    <= acc_q[2] & pwm_on;
        led_g    <= acc_q[1] & pwm_on;
        led_b    <= acc_q[0] & pwm_on;
        flashing <= 1'b0;
      end
    end
  end

endmodule
